window_watchdog: RTL
====================

# window_watchdog

Parametrised windowed watchdog: a key-protected register file, a frame counter with a closed (too-early) window and an open (service) window, a fault classifier and a programmable-length reset pulse generator. It generalises the current fixed 8-bit watchdog with these additions: configurable data/counter width, explicit early/late/bad-key fault codes, a fault counter and an enable control. It sits between the host bus (ABUS/DBUS) and the system reset tree.

## Interface
- DW, 8: data and counter width; all length registers and FAILCNT are DW bits.
- UNLOCK_KEY, 8'hA5: value at address 0 that unlocks the next configuration write.
- SERVICE_KEY, 8'h5A: value at address 5 that counts as a valid service.
- RST_LEN_DEF, 16: reset value of RST_LEN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR  in  1  write strobe; ABUS/DBUS are sampled when WR=1.
- ABUS  in  3  register address.
- DBUS  in  DW  write data.
- RSTOUT  out  1  registered, active-high system reset pulse.
- FLSTAT  out  2  sticky fault code: 00 none, 01 early, 10 late, 11 bad key.
- FAILCNT  out  DW  count of faults; saturates at all-ones.
- STATE  out  2  state: 00 DISABLED, 01 CLOSED, 10 OPEN, 11 RESET_OUT.

## Operation
- Address map (write-only):
  - 0 KEY: UNLOCK_KEY sets `unlk`; any other value clears it.
  - 1 CLOSED_LEN, 2 FRAME_LEN, 3 RST_LEN.
  - 4 CTRL: bit0 = EN.
  - 5 SERVICE.
  - 6 CLR: clears FLSTAT and FAILCNT; data ignored.
  - 7: no effect.
- Addresses 1,2,3,4,6 are protected. The write takes effect only if `unlk`=1. `unlk` clears after any WR=1 cycle whose address is not 0, including ignored writes.
- SERVICE writes need no unlock.
- Frame counter `cnt` (DW bits) is 0 at frame start and increments every cycle in CLOSED/OPEN.
- DISABLED: `cnt` held at 0, services ignored. EN 0→1 enters CLOSED with `cnt`=0 on the next edge.
- CLOSED (`cnt` < CLOSED_LEN):
  - SERVICE with SERVICE_KEY → early fault.
  - SERVICE with any other data → bad-key fault.
  - When `cnt` = CLOSED_LEN-1, go to OPEN.
  - CLOSED_LEN=0 means OPEN is entered directly at frame start.
- OPEN:
  - SERVICE with SERVICE_KEY → good service: CLOSED, `cnt`=0.
  - Wrong data → bad-key fault.
  - No service by the edge where `cnt` = FRAME_LEN-1 → late fault.
  - A valid service on that same edge wins (good service).
- CLOSED_LEN ≥ FRAME_LEN: there is no open window. A service is early; a timeout at `cnt` = FRAME_LEN-1 is late.
- FRAME_LEN=0 is treated as 1.
- Fault handling:
  - FLSTAT is loaded with the code only if it is currently 00 (the first fault is kept).
  - FAILCNT increments, saturating at all-ones.
  - State goes to RESET_OUT.
- RESET_OUT:
  - RSTOUT=1 for max(RST_LEN,1) cycles, counted by an internal down-counter.
  - Services are ignored.
  - Register writes still apply.
  - On exit: CLOSED with `cnt`=0 if EN=1, else DISABLED.
- EN cleared while in CLOSED/OPEN → DISABLED next edge, no fault. EN cleared in RESET_OUT → the pulse completes first.
- Length registers written mid-frame take effect immediately. Comparisons use the current register values.
- Reset values:
  - CLOSED_LEN=0, FRAME_LEN=all-ones, RST_LEN=RST_LEN_DEF, EN=0.
  - `unlk`=0, `cnt`=0, RSTOUT=0, FLSTAT=00, FAILCNT=0, STATE=DISABLED.
- RST asserted mid-pulse drops RSTOUT immediately (asynchronously).

## Timing
- Every write, service and timeout is decided on the rising edge where it is sampled (edge k). STATE and FLSTAT change at edge k.
- RSTOUT rises at edge k, is high for exactly max(RST_LEN,1) cycles, then falls. STATE returns to CLOSED/DISABLED at that same edge.
- With no service, a late fault occurs FRAME_LEN cycles after frame start.
- A fault and a CLR write on the same edge: the fault wins. FLSTAT takes the new code and FAILCNT=1.
- KEY write followed by a protected write on the next WR cycle: accepted regardless of idle cycles between them.

## Test plan
- Reset, then KEY A5, then CTRL=1 (CLOSED_LEN=0, FRAME_LEN=FF) → STATE=10. With no service, RSTOUT goes high after 255 cycles for 16 cycles; FLSTAT=10, FAILCNT=1.
- CLOSED_LEN=4, FRAME_LEN=10, EN=1; SERVICE 5A at `cnt`=2 → FLSTAT=01, RSTOUT high 16 cycles. SERVICE at `cnt`=6 → no fault, `cnt` restarts at 0.
- SERVICE with data 33 in OPEN → FLSTAT=11, FAILCNT increments. A second fault keeps FLSTAT=11 and FAILCNT=2.
- Protected write without KEY (FRAME_LEN=20) → ignored. KEY 00 then a write → ignored. KEY A5, a write to addr 7, then FRAME_LEN=20 → ignored.
- RST_LEN=0 → RSTOUT pulse lasts 1 cycle. RST_LEN=3 with EN cleared during the pulse → 3 cycles, then STATE=00.
- Assert RST mid-pulse → RSTOUT=0 immediately; all registers return to their reset values. Valid service on the FRAME_LEN-1 edge → no fault.

Source files
------------

// File: rtl/window_watchdog.sv
// Windowed watchdog: key-protected configuration registers, a frame counter with
// closed/open service windows, a sticky fault classifier and a reset pulse generator.
module window_watchdog #(
  parameter int              DW          = 8,
  parameter logic [DW-1:0]   UNLOCK_KEY  = DW'(8'hA5),
  parameter logic [DW-1:0]   SERVICE_KEY = DW'(8'h5A),
  parameter logic [DW-1:0]   RST_LEN_DEF = DW'(16)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [2:0]    abus,
  input  logic [DW-1:0] dbus,
  output logic          rstout,
  output logic [1:0]    flstat,
  output logic [DW-1:0] failcnt,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_DISABLED  = 2'b00,
    S_CLOSED    = 2'b01,
    S_OPEN      = 2'b10,
    S_RESET_OUT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_NONE   = 2'b00,
    F_EARLY  = 2'b01,
    F_LATE   = 2'b10,
    F_BADKEY = 2'b11
  } fault_t;

  state_t        state_q, state_n;
  fault_t        fault;
  logic [DW-1:0] closed_len, frame_len, rst_len;
  logic          en, unlk;
  logic [DW-1:0] cnt, cnt_n;
  logic [DW-1:0] rcnt, rcnt_n;

  // Bus decode
  logic          svc, svc_ok, prot_wr, clr;
  logic          timeout, open_reached;
  logic [DW-1:0] frame_lim, rst_load;
  state_t        start_state;

  assign svc     = wr && (abus == 3'd5);
  assign svc_ok  = (dbus == SERVICE_KEY);
  assign prot_wr = wr && unlk && (abus inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6});
  assign clr     = prot_wr && (abus == 3'd6);

  // Inequalities rather than equality so that shrinking a length mid-frame
  // cannot let the counter run past the limit and wrap.
  assign frame_lim    = (frame_len == '0) ? '0 : frame_len - 1'b1;
  assign timeout      = (cnt >= frame_lim);
  assign open_reached = (closed_len == '0) || (cnt >= closed_len - 1'b1);
  assign start_state  = (closed_len == '0) ? S_OPEN : S_CLOSED;
  assign rst_load     = (rst_len == '0) ? '0 : rst_len - 1'b1;

  // Register file and unlock latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      closed_len <= '0;
      frame_len  <= '1;
      rst_len    <= RST_LEN_DEF;
      en         <= 1'b0;
      unlk       <= 1'b0;
    end else if (wr) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      unlk <= (abus == 3'd0) && (dbus == UNLOCK_KEY);
      if (prot_wr) begin
        case (abus)
          3'd1:    closed_len <= dbus;
          3'd2:    frame_len  <= dbus;
          3'd3:    rst_len    <= dbus;
          3'd4:    en         <= dbus[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_n = state_q;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    fault   = F_NONE;
    case (state_q)
      S_DISABLED: begin
        cnt_n = '0;
        if (en) state_n = start_state;
      end
      S_CLOSED: begin
        if (!en) begin
          state_n = S_DISABLED;
          cnt_n   = '0;
        end else if (svc) begin
          fault = svc_ok ? F_EARLY : F_BADKEY;
        end else if (timeout) begin
          fault = F_LATE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (open_reached) state_n = S_OPEN;
        end
      end
      S_OPEN: begin
        if (!en) begin
          state_n = S_DISABLED;
          cnt_n   = '0;
        end else if (svc) begin
          if (svc_ok) begin
            state_n = start_state;
            cnt_n   = '0;
          end else begin
            fault = F_BADKEY;
          end
        end else if (timeout) begin
          fault = F_LATE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RESET_OUT: begin
        cnt_n = '0;
        if (rcnt == '0) state_n = en ? start_state : S_DISABLED;
        else            rcnt_n  = rcnt - 1'b1;
      end
      default: state_n = S_DISABLED;
    endcase
    if (fault != F_NONE) begin
      state_n = S_RESET_OUT;
      cnt_n   = '0;
      rcnt_n  = rst_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DISABLED;
      cnt     <= '0;
      rcnt    <= '0;
      rstout  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt     <= cnt_n;
      rcnt    <= rcnt_n;
      rstout  <= (state_n == S_RESET_OUT);
    end
  end

  // First fault code is sticky; a fault coinciding with CLR replaces the cleared state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flstat  <= F_NONE;
      failcnt <= '0;
    end else if (fault != F_NONE) begin
      if (clr || flstat == F_NONE) flstat <= fault;
      if (clr)            failcnt <= DW'(1);
      else if (!(&failcnt)) failcnt <= failcnt + 1'b1;
    end else if (clr) begin
      flstat  <= F_NONE;
      failcnt <= '0;
    end
  end

  assign state = state_q;

endmodule
